countdown_timer: RTL and testbench

- Time-keeping core of the microwave. Accepts keypad digits, then counts the mm:ss value down to 0:00 once per second while cooking.
- Drives the three BCD digits (min, sec_tens, sec_ones) consumed directly by the 7-segment decoder stage.
- Also drives the heating-enable and end-of-cycle flags.
- A single FSM controls entry, run, pause and clear, with an internal prescaler that generates the 1 s tick.

---
 rtl/countdown_timer_if.sv | 33 +++
 rtl/countdown_timer.sv | 139 +++++++++++++
 tb/tb_countdown_timer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Keypad/display bundle of the microwave countdown timer.
//   digit       keypad BCD digit, qualified by digit_valid (one-cycle strobe)
//   start       start/resume pulse
//   stop        pause/clear pulse
//   door_open   level, 1 = door open
//   min         BCD minutes 0-9
//   sec_tens    BCD tens of seconds 0-5
//   sec_ones    BCD units of seconds 0-9
//   running     1 while counting (magnetron enable)
//   done        one-cycle pulse when the count reaches 0:00
// master = keypad/controller side, slave = timer core.
interface countdown_timer_if;
  logic [3:0] digit;
  logic       digit_valid;
  logic       start;
  logic       stop;
  logic       door_open;
  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;

  modport master (
    output digit, digit_valid, start, stop, door_open,
    input  min, sec_tens, sec_ones, running, done
  );

  modport slave (
    input  digit, digit_valid, start, stop, door_open,
    output min, sec_tens, sec_ones, running, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Time-keeping core of the microwave: keypad entry of an m:ss value, then a
// once-per-second countdown to 0:00 with pause/resume/clear control.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    countdown_timer_if.slave (keypad inputs, BCD digits, flags)
// Parameter TICK_DIV: clk cycles per second (>= 2).
module countdown_timer #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  countdown_timer_if.slave   bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    min_q, tens_q, ones_q;
  logic          running_q, done_q;

  // One-second-down value of the current display.
  logic [3:0] min_d, tens_d, ones_d;
  logic       dec_zero;
  logic       value_zero;
  logic       digit_ok;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    min_d  = min_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (ones_q != 4'd0) begin
      ones_d = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      tens_d = tens_q - 4'd1;
      ones_d = 4'd9;
    end else begin
      min_d  = min_q - 4'd1;
      tens_d = 4'd5;
      ones_d = 4'd9;
    end
  end

  assign dec_zero   = (min_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd0);
  assign value_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  // Shifting sec_ones into sec_tens must keep sec_tens within 0-5.
  assign digit_ok   = (bus.digit <= 4'd9) && (ones_q <= 4'd5);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  // NOTE: reset is sampled synchronously here and overrides every other action.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      min_q     <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.stop) begin
            min_q  <= 4'd0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
          end else if (bus.start) begin
            // A start always swallows a simultaneous digit, even if refused.
            if (!bus.door_open && !value_zero) begin
              state_q   <= RUNNING;
              running_q <= 1'b1;
              presc_q   <= '0;
            end
          end else if (bus.digit_valid && digit_ok) begin
            min_q  <= tens_q;
            tens_q <= ones_q;
            ones_q <= bus.digit;
          end
        end

        RUNNING: begin
          if (bus.stop || bus.door_open) begin
            // Tick on this edge is dropped; value and prescaler freeze.
            state_q   <= PAUSED;
            running_q <= 1'b0;
          end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            if (dec_zero) begin
              state_q   <= IDLE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end

        PAUSED: begin
          if (bus.stop) begin
            state_q <= IDLE;
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
          end else if (bus.start && !bus.door_open) begin
            state_q   <= RUNNING;
            running_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.min      = min_q;
  assign bus.sec_tens = tens_q;
  assign bus.sec_ones = ones_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with TICK_DIV = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  countdown_timer_if bus ();

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] value();
    return {bus.min, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic check_val(input string tag, input logic [11:0] exp);
    check(tag, value(), exp);
  endtask

  task automatic check_run(input string tag, input logic exp);
    check(tag, {11'd0, bus.running}, {11'd0, exp});
  endtask

  task automatic check_done(input string tag, input logic exp);
    check(tag, {11'd0, bus.done}, {11'd0, exp});
  endtask

  task automatic press(input logic [3:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    cycle();
    bus.digit_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.digit       = 4'd0;
    bus.digit_valid = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.door_open   = 1'b0;

    // Reset state
    @(negedge clk);
    cycle(2);
    check_val("reset_value", 12'h000);
    check_run("reset_running", 1'b0);
    check_done("reset_done", 1'b0);
    rst_n = 1'b1;

    // 1. Digit entry and shift, old minute dropped
    press(4'd1); press(4'd3); press(4'd0);
    check_val("entry_130", 12'h130);
    press(4'd7);
    check_val("entry_307", 12'h307);

    // 2. Legality checks
    pulse_stop();
    check_val("idle_stop_clear", 12'h000);
    press(4'd0); press(4'd7);
    check_val("entry_007", 12'h007);
    press(4'd8);
    check_val("ones_gt5_ignored", 12'h007);
    pulse_stop();
    press(4'd2);
    press(4'hA);
    check_val("digit_A_ignored", 12'h002);

    // 3. Count 1:01 down
    pulse_stop();
    press(4'd1); press(4'd0); press(4'd1);
    check_val("load_101", 12'h101);
    pulse_start();
    check_run("running_after_start", 1'b1);
    cycle(3);
    check_val("no_tick_yet", 12'h101);
    cycle(1);
    check_val("tick1_100", 12'h100);
    cycle(4);
    check_val("tick2_059", 12'h059);
    cycle(4);
    check_val("tick3_058", 12'h058);
    pulse_stop();
    check_run("stop_pauses", 1'b0);
    check_val("pause_holds", 12'h058);
    pulse_stop();
    check_val("second_stop_clears", 12'h000);

    // 4. Count 0:02 to zero
    press(4'd0); press(4'd2);
    pulse_start();
    cycle(4);
    check_val("z_tick1_001", 12'h001);
    cycle(3);
    check_run("z_still_running", 1'b1);
    check_done("z_done_low_before", 1'b0);
    cycle(1);
    check_val("z_reached_000", 12'h000);
    check_run("z_running_low", 1'b0);
    check_done("z_done_pulse", 1'b1);
    cycle(1);
    check_done("z_done_one_cycle", 1'b0);
    pulse_start();
    check_run("z_start_on_zero_ignored", 1'b0);

    // 5. Door pause, resume with remaining prescale, stop/stop
    press(4'd3); press(4'd0);
    pulse_start();
    cycle(2);
    check_val("p_before_door", 12'h030);
    bus.door_open = 1'b1;
    cycle(1);
    check_run("p_door_pauses", 1'b0);
    cycle(5);
    check_val("p_frozen", 12'h030);
    pulse_start();
    check_run("p_start_door_open_ignored", 1'b0);
    bus.door_open = 1'b0;
    cycle(1);
    pulse_start();
    check_run("p_resume", 1'b1);
    check_val("p_resume_value", 12'h030);
    cycle(1);
    check_val("p_no_tick_yet", 12'h030);
    cycle(1);
    check_val("p_remaining_tick", 12'h029);
    pulse_stop();
    check_run("p_stop_pause", 1'b0);
    check_val("p_stop_holds", 12'h029);
    pulse_stop();
    check_val("p_stop_clear", 12'h000);
    check_done("p_clear_no_done", 1'b0);

    // 6. Mid-count reset
    press(4'd2); press(4'd1); press(4'd5);
    pulse_start();
    cycle(2);
    rst_n = 1'b0;
    cycle(1);
    check_val("r_reset_value", 12'h000);
    check_run("r_reset_running", 1'b0);
    check_done("r_reset_done", 1'b0);
    rst_n = 1'b1;
    cycle(5);
    check_run("r_stays_idle", 1'b0);

    // start+stop together in PAUSED clears
    press(4'd4); press(4'd5);
    pulse_start();
    cycle(1);
    pulse_stop();
    check_val("c_paused_045", 12'h045);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_val("c_start_stop_clear", 12'h000);
    check_run("c_not_running", 1'b0);
    pulse_start();
    check_run("c_start_zero_idle", 1'b0);

    // start+digit together in IDLE: start wins, digit dropped
    press(4'd1);
    bus.digit       = 4'd2;
    bus.digit_valid = 1'b1;
    bus.start       = 1'b1;
    cycle(1);
    bus.digit_valid = 1'b0;
    bus.start       = 1'b0;
    check_run("s_start_wins", 1'b1);
    check_val("s_digit_dropped", 12'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
